// File: rtl/exu_ctrl.sv
// Execute-stage control: passes single-cycle ops straight to the M-pipe and sequences multi-cycle MDU ops.
// Optional mispredict redirect register enabled by defining YSYX_23060251_EXU_REDIRECT_EN.
module exu_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MDU_LAT = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            E_valid_i,
   input  logic            is_multi_i,
   input  logic            M_ready_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] npc_i,
   input  logic [XLEN-1:0] pred_pc_i,
   output logic            e_ready_o,
   output logic            e_valid_o,
   output logic            mdu_start_o,
   output logic            mdu_kill_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   localparam int unsigned CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             issue;

   // Reset gates issue so start stays low and the IDLE path stays transparent while rst_n is low.
   assign issue = rst_n & E_valid_i & is_multi_i & ~flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Flush wins over counter expiry and the DONE handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (issue) begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(MDU_LAT - 1);
               end
            end
            S_BUSY: begin
               if (cnt_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (M_ready_i) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      e_valid_o   = 1'b0;
      e_ready_o   = 1'b0;
      mdu_start_o = 1'b0;
      mdu_kill_o  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               mdu_start_o = 1'b1;
            end else begin
               e_valid_o = E_valid_i & ~flush_i;
               e_ready_o = M_ready_i;
            end
         end
         S_BUSY: begin
            mdu_kill_o = flush_i;
         end
         S_DONE: begin
            e_valid_o = ~flush_i;
            e_ready_o = M_ready_i;
         end
         default: begin
            e_valid_o = 1'b0;
         end
      endcase
   end

`ifdef YSYX_23060251_EXU_REDIRECT_EN
   logic            redirect_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            mispredict;

   // e_valid_o already carries ~flush_i, so a flushed cycle never redirects.
   assign mispredict = e_valid_o & M_ready_i & (npc_i != pred_pc_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         redirect_q <= mispredict;
         if (mispredict) begin
            redirect_pc_q <= npc_i;
         end
      end
   end

   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;
`else
   logic unused_pc;

   assign unused_pc     = ^{npc_i, pred_pc_i};
   assign redirect_o    = 1'b0;
   assign redirect_pc_o = '0;
`endif

endmodule

// File: doc/exu_ctrl.md
EXU_CTRL -- requirements
Module: exu_ctrl

Interface
REQ-001 Parameter XLEN, default 32, width of npc_i, pred_pc_i and redirect_pc_o.
REQ-002 Parameter MDU_LAT, default 32, multi-cycle op latency in cycles, legal range 2..64.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 E_valid_i  input  1  E-pipe holds a valid instruction.
REQ-006 is_multi_i  input  1  instruction uses the multi-cycle MDU; qualified by E_valid_i.
REQ-007 M_ready_i  input  1  M-pipe can accept a result this cycle.
REQ-008 flush_i  input  1  kill the in-flight instruction.
REQ-009 npc_i  input  XLEN  resolved next PC from the execute datapath.
REQ-010 pred_pc_i  input  XLEN  predicted next PC carried with the instruction.
REQ-011 e_ready_o  output  1  execute stage accepts the E-pipe instruction.
REQ-012 e_valid_o  output  1  result valid toward the M-pipe.
REQ-013 mdu_start_o  output  1  one-cycle MDU start pulse.
REQ-014 mdu_kill_o  output  1  one-cycle MDU abort pulse.
REQ-015 redirect_o  output  1  registered one-cycle mispredict redirect.
REQ-016 redirect_pc_o  output  XLEN  redirect target, valid while redirect_o=1.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE plus a down-counter of width clog2(MDU_LAT).
REQ-018 In IDLE with is_multi_i=0, the block SHALL be transparent: e_valid_o=E_valid_i&~flush_i, e_ready_o=M_ready_i.
REQ-019 In IDLE with E_valid_i=1, is_multi_i=1, flush_i=0: mdu_start_o=1 and e_valid_o=0 and e_ready_o=0 the same cycle; next state BUSY; counter loads MDU_LAT-1.
REQ-020 In BUSY: e_valid_o=0, e_ready_o=0; counter decrements each cycle; at counter=0 the next state is DONE.
REQ-021 The first cycle e_valid_o=1 SHALL occur exactly MDU_LAT+1 cycles after the mdu_start_o cycle.
REQ-022 In DONE: e_valid_o=1, e_ready_o=M_ready_i; the state holds while M_ready_i=0; M_ready_i=1 gives next state IDLE.
REQ-023 A handshake occurs on any cycle with e_valid_o=1 and M_ready_i=1.
REQ-024 flush_i=1 in any state SHALL force e_valid_o=0 and mdu_start_o=0, with next state IDLE.
REQ-025 flush_i=1 in BUSY SHALL also assert mdu_kill_o for that cycle. mdu_kill_o SHALL otherwise remain 0.
REQ-026 flush_i has priority over every same-cycle event, including counter expiry and a DONE handshake.
REQ-027 mdu_start_o SHALL never assert in two consecutive cycles.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, mdu_start_o=0, mdu_kill_o=0, redirect_o=0 and redirect_pc_o=0.
REQ-029 e_valid_o and e_ready_o SHALL follow REQ-018 during reset.
REQ-030 If reset is asserted while BUSY, the operation is discarded without mdu_kill_o; after reset the block SHALL accept a new instruction.

Configuration
REQ-031 With macro YSYX_23060251_EXU_REDIRECT_EN defined, the block SHALL register redirect_o=1 and redirect_pc_o=npc_i on the cycle after a handshake with flush_i=0 and npc_i!=pred_pc_i.
REQ-032 Otherwise, with the macro defined, redirect_o=0 and redirect_pc_o SHALL hold its last value.
REQ-033 Without the macro, redirect_o and redirect_pc_o SHALL be constant 0, and no comparator or registers SHALL be built for them.

Verification
REQ-034 Reset, then IDLE with E_valid_i=1, is_multi_i=0, M_ready_i=1 -> e_valid_o=1, e_ready_o=1, mdu_start_o=0, same cycle.
REQ-035 MDU_LAT=32, multi op issued at cycle 0, M_ready_i=1 -> mdu_start_o at cycle 0; e_valid_o first 1 at cycle 33; IDLE at cycle 34.
REQ-036 Multi op reaches DONE, M_ready_i=0 for 5 cycles then 1 -> e_valid_o held 1 for 6 cycles, e_ready_o=1 only in the last.
REQ-037 flush_i=1 at BUSY cycle 10 -> mdu_kill_o=1 that cycle, IDLE next, e_valid_o never 1; a new multi op on the next cycle restarts with full latency.
REQ-038 Macro defined, handshake with npc_i=0x80000010, pred_pc_i=0x80000004 -> redirect_o=1 one cycle later, redirect_pc_o=0x80000010. With equal PCs -> redirect_o stays 0.
REQ-039 rst_n pulsed low mid-BUSY -> all outputs at reset values immediately, mdu_kill_o=0; after release, a multi op takes the full MDU_LAT+1 cycles.
